// File: rtl/cr_prefix_detach_ctlr.sv
// cr_prefix_detach_ctlr
//   Receive-side prefix detach. Pops TLV words from the user inbound FIFO,
//   drops complete PFD/PHD TLVs (sot word through eot word) and forwards
//   every other word unchanged to the outbound FIFO. For each dropped TLV
//   the data-word count is checked against the required length and the
//   prefix number (tdata[5:0] of the sot word) is captured.
//
//   TLV word layout (70 bits):
//     [69]    sot
//     [68]    eot
//     [67:64] typen
//     [63:0]  tdata
//
//   Ports
//     clk, rst_n                  clock, async active-low reset
//     usr_ib_empty/aempty/tlv/rd  inbound FIFO (data valid cycle after rd)
//     usr_ob_full/afull/wr/tlv    outbound FIFO
//     pdc_prefix_num              prefix of the last stripped sot word
//     pdc_strip_pulse             pulse per stripped TLV
//     pdc_len_err                 pulse on a stripped TLV of wrong length
//     pdc_proto_err               pulse on a sot/eot framing violation
//     pdc_strip_cnt               stripped TLV count (wraps)

`ifndef N_PFD_WORDS
`define N_PFD_WORDS 3
`endif
`ifndef N_PHD_WORDS
`define N_PHD_WORDS 2
`endif

module cr_prefix_detach_ctlr #(
   parameter bit         STRIP_PFD = 1'b1,
   parameter bit         STRIP_PHD = 1'b1,
   parameter int         PFD_WORDS = `N_PFD_WORDS,
   parameter int         PHD_WORDS = `N_PHD_WORDS,
   parameter logic [3:0] TYPE_PFD  = 4'h1,
   parameter logic [3:0] TYPE_PHD  = 4'h2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        usr_ib_empty,
   input  logic        usr_ib_aempty,
   input  logic [69:0] usr_ib_tlv,
   output logic        usr_ib_rd,
   input  logic        usr_ob_full,
   input  logic        usr_ob_afull,
   output logic        usr_ob_wr,
   output logic [69:0] usr_ob_tlv,
   output logic [5:0]  pdc_prefix_num,
   output logic        pdc_strip_pulse,
   output logic        pdc_len_err,
   output logic        pdc_proto_err,
   output logic [31:0] pdc_strip_cnt
);

   localparam logic [8:0] PFD_REQ = 9'(PFD_WORDS);
   localparam logic [8:0] PHD_REQ = 9'(PHD_WORDS);

   typedef enum logic [1:0] {S_SOT, S_PASS, S_STRIP} state_t;

   state_t     state, nxt_state;
   logic       valid0;
   logic [7:0] word_cnt, nxt_cnt;
   logic       cur_pfd, nxt_pfd;
   logic [5:0] nxt_prefix;
   logic       wr_d, len_d, proto_d, eval_sot;
   logic [1:0] strip_inc;

   // almost-empty is not needed for pacing; kept only for port symmetry
   logic unused_aempty;
   assign unused_aempty = usr_ib_aempty;

   // Stage 0 word: the FIFO presents read data the cycle after the pop,
   // which is exactly the cycle valid0 is high.
   logic       in_sot, in_eot, is_strip;
   logic [3:0] in_type;
   assign in_sot   = usr_ib_tlv[69];
   assign in_eot   = usr_ib_tlv[68];
   assign in_type  = usr_ib_tlv[67:64];
   assign is_strip = ((in_type == TYPE_PFD) && STRIP_PFD) ||
                     ((in_type == TYPE_PHD) && STRIP_PHD);

   // Pop only while the words already in flight (valid0 and the output
   // register) still fit in the afull headroom.
   assign usr_ib_rd = rst_n & ~usr_ib_empty & ~usr_ob_full &
                      ~(usr_ob_afull & (valid0 | usr_ob_wr));

   logic [8:0] cnt_plus1, req_words;
   assign cnt_plus1 = {1'b0, word_cnt} + 9'd1;
   assign req_words = cur_pfd ? PFD_REQ : PHD_REQ;

   always_comb begin
      nxt_state  = state;
      nxt_cnt    = word_cnt;
      nxt_pfd    = cur_pfd;
      nxt_prefix = pdc_prefix_num;
      wr_d       = 1'b0;
      len_d      = 1'b0;
      proto_d    = 1'b0;
      eval_sot   = 1'b0;
      strip_inc  = 2'd0;
      if (valid0) begin
         case (state)
            S_SOT: eval_sot = 1'b1;
            S_PASS: begin
               if (in_sot) begin
                  proto_d  = 1'b1;
                  eval_sot = 1'b1;
               end else begin
                  wr_d = 1'b1;
                  if (in_eot) nxt_state = S_SOT;
               end
            end
            S_STRIP: begin
               if (in_sot) begin
                  // unterminated stripped TLV: close it as short, then
                  // treat this word as a fresh TLV start
                  proto_d   = 1'b1;
                  len_d     = 1'b1;
                  strip_inc = 2'd1;
                  eval_sot  = 1'b1;
               end else begin
                  if (word_cnt != 8'hFF) nxt_cnt = word_cnt + 8'd1;
                  if (in_eot) begin
                     strip_inc = 2'd1;
                     len_d     = (cnt_plus1 != req_words);
                     nxt_state = S_SOT;
                  end
               end
            end
            default: nxt_state = S_SOT;
         endcase

         if (eval_sot) begin
            if (!in_sot) begin
               proto_d   = 1'b1;
               wr_d      = 1'b1;
               nxt_state = S_SOT;
            end else if (is_strip) begin
               nxt_prefix = usr_ib_tlv[5:0];
               nxt_pfd    = (in_type == TYPE_PFD);
               nxt_cnt    = 8'd0;
               if (in_eot) begin
                  // sot+eot on one word carries no data words
                  len_d     = 1'b1;
                  strip_inc = strip_inc + 2'd1;
                  nxt_state = S_SOT;
               end else begin
                  nxt_state = S_STRIP;
               end
            end else begin
               wr_d      = 1'b1;
               nxt_state = in_eot ? S_SOT : S_PASS;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_SOT;
         valid0          <= 1'b0;
         word_cnt        <= 8'd0;
         cur_pfd         <= 1'b0;
         usr_ob_wr       <= 1'b0;
         usr_ob_tlv      <= '0;
         pdc_prefix_num  <= 6'd0;
         pdc_strip_pulse <= 1'b0;
         pdc_len_err     <= 1'b0;
         pdc_proto_err   <= 1'b0;
         pdc_strip_cnt   <= 32'd0;
      end else begin
         valid0          <= usr_ib_rd;
         state           <= nxt_state;
         word_cnt        <= nxt_cnt;
         cur_pfd         <= nxt_pfd;
         pdc_prefix_num  <= nxt_prefix;
         usr_ob_wr       <= wr_d;
         if (wr_d) usr_ob_tlv <= usr_ib_tlv;
         pdc_strip_pulse <= (strip_inc != 2'd0);
         pdc_len_err     <= len_d;
         pdc_proto_err   <= proto_d;
         pdc_strip_cnt   <= pdc_strip_cnt + {30'd0, strip_inc};
      end
   end

endmodule

// File: tb/tb_cr_prefix_detach_ctlr.sv
// Directed bench for cr_prefix_detach_ctlr: a queue-backed inbound FIFO
// model, an output monitor, and hand-computed expectations per scenario.
module tb_cr_prefix_detach_ctlr;

   localparam logic [3:0] T_DATA = 4'h0;
   localparam logic [3:0] T_PFD  = 4'h1;
   localparam logic [3:0] T_PHD  = 4'h2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        usr_ib_empty = 1'b1;
   logic        usr_ib_aempty;
   logic [69:0] usr_ib_tlv = '0;
   logic        usr_ib_rd;
   logic        usr_ob_full;
   logic        usr_ob_afull;
   logic        usr_ob_wr;
   logic [69:0] usr_ob_tlv;
   logic [5:0]  pdc_prefix_num;
   logic        pdc_strip_pulse, pdc_len_err, pdc_proto_err;
   logic [31:0] pdc_strip_cnt;

   logic        ib_rd2, ob_wr2;
   logic [69:0] ob_tlv2;
   logic [5:0]  prefix2;
   logic        strip2, len2, proto2;
   logic [31:0] strip_cnt2;

   always #5 clk = ~clk;

   cr_prefix_detach_ctlr #(.STRIP_PFD(1'b1), .STRIP_PHD(1'b1),
      .PFD_WORDS(3), .PHD_WORDS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .usr_ib_empty(usr_ib_empty), .usr_ib_aempty(usr_ib_aempty),
      .usr_ib_tlv(usr_ib_tlv), .usr_ib_rd(usr_ib_rd),
      .usr_ob_full(usr_ob_full), .usr_ob_afull(usr_ob_afull),
      .usr_ob_wr(usr_ob_wr), .usr_ob_tlv(usr_ob_tlv),
      .pdc_prefix_num(pdc_prefix_num), .pdc_strip_pulse(pdc_strip_pulse),
      .pdc_len_err(pdc_len_err), .pdc_proto_err(pdc_proto_err),
      .pdc_strip_cnt(pdc_strip_cnt));

   // PFD stripping disabled; shares the inbound stream (its pop matches
   // the main instance whenever afull is low)
   cr_prefix_detach_ctlr #(.STRIP_PFD(1'b0), .STRIP_PHD(1'b1),
      .PFD_WORDS(3), .PHD_WORDS(2)) dut_nopfd (
      .clk(clk), .rst_n(rst_n),
      .usr_ib_empty(usr_ib_empty), .usr_ib_aempty(usr_ib_aempty),
      .usr_ib_tlv(usr_ib_tlv), .usr_ib_rd(ib_rd2),
      .usr_ob_full(usr_ob_full), .usr_ob_afull(usr_ob_afull),
      .usr_ob_wr(ob_wr2), .usr_ob_tlv(ob_tlv2),
      .pdc_prefix_num(prefix2), .pdc_strip_pulse(strip2),
      .pdc_len_err(len2), .pdc_proto_err(proto2),
      .pdc_strip_cnt(strip_cnt2));

   // inbound FIFO model: pop on rd, data shows up the following cycle
   logic [69:0] ib_q[$];
   always @(posedge clk) begin
      if (usr_ib_rd && ib_q.size() > 0) usr_ib_tlv <= ib_q.pop_front();
      usr_ib_empty <= (ib_q.size() == 0);
   end

   // monitor
   logic [69:0] ob_q[$], ob2_q[$];
   int cyc = 0, first_rd, first_wr;
   int n_strip, n_len, n_proto, n_strip_len, n_proto_len;
   int rd_full_viol, afull_viol;
   logic rd_d1 = 1'b0, rd_d2 = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (usr_ob_wr) begin
         ob_q.push_back(usr_ob_tlv);
         if (first_wr < 0) first_wr = cyc;
      end
      if (ob_wr2) ob2_q.push_back(ob_tlv2);
      if (usr_ib_rd && first_rd < 0) first_rd = cyc;
      if (pdc_strip_pulse) n_strip++;
      if (pdc_len_err) n_len++;
      if (pdc_proto_err) n_proto++;
      if (pdc_strip_pulse && pdc_len_err) n_strip_len++;
      if (pdc_proto_err && pdc_len_err) n_proto_len++;
      if (usr_ib_rd && usr_ob_full) rd_full_viol++;
      if (usr_ib_rd && usr_ob_afull && (rd_d1 || rd_d2)) afull_viol++;
      rd_d2 = rd_d1;
      rd_d1 = usr_ib_rd;
   end

   int n_chk = 0, n_fail = 0;
   int bp_en = 0, bp_k = 0;

   task automatic chk(input string tag, input logic [69:0] got,
                      input logic [69:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [69:0] mk(input bit s, input bit e,
                                      input logic [3:0] t,
                                      input logic [63:0] d);
      return {s, e, t, d};
   endfunction

   task automatic clear_mon();
      ob_q.delete(); ob2_q.delete();
      first_rd = -1; first_wr = -1;
      n_strip = 0; n_len = 0; n_proto = 0; n_strip_len = 0; n_proto_len = 0;
      rd_full_viol = 0; afull_viol = 0;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (bp_en != 0) begin
            bp_k++;
            if (bp_k % 3 == 0) usr_ob_full = ~usr_ob_full;
         end
      end
   endtask

   function automatic logic [69:0] ob_at(input int i);
      return (ob_q.size() > i) ? ob_q[i] : 'x;
   endfunction

   logic [69:0] exp_w[$];
   int bad;

   initial begin
      rst_n = 1'b0; usr_ib_aempty = 1'b0;
      usr_ob_full = 1'b0; usr_ob_afull = 1'b0;
      clear_mon();
      run(3);
      chk("rst_ob_wr",  usr_ob_wr, 0);
      chk("rst_ob_tlv", usr_ob_tlv, 0);
      chk("rst_cnt",    pdc_strip_cnt, 0);
      chk("rst_prefix", pdc_prefix_num, 0);
      chk("rst_pulses", {pdc_strip_pulse, pdc_len_err, pdc_proto_err}, 0);
      chk("rst_ib_rd",  usr_ib_rd, 0);
      rst_n = 1'b1;
      run(2);

      // forward-only DATA TLV
      clear_mon(); exp_w.delete();
      for (int i = 0; i < 4; i++)
         exp_w.push_back(mk(i == 0, i == 3, T_DATA, 64'h1000 + 64'(i)));
      foreach (exp_w[i]) ib_q.push_back(exp_w[i]);
      run(20);
      chk("fwd_count", ob_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("fwd_w%0d", i), ob_at(i), exp_w[i]);
      chk("fwd_latency", first_wr - first_rd, 2);
      chk("fwd_pulses", n_strip + n_len + n_proto, 0);

      // exact-length PFD strip followed by DATA; nopfd instance forwards all
      clear_mon(); exp_w.delete();
      exp_w.push_back(mk(1, 0, T_PFD, 64'hAA));
      for (int i = 0; i < 3; i++) exp_w.push_back(mk(0, i == 2, T_PFD, 64'h200 + 64'(i)));
      exp_w.push_back(mk(1, 0, T_DATA, 64'h300));
      exp_w.push_back(mk(0, 1, T_DATA, 64'h301));
      foreach (exp_w[i]) ib_q.push_back(exp_w[i]);
      run(25);
      chk("pfd_count", ob_q.size(), 2);
      chk("pfd_w0", ob_at(0), exp_w[4]);
      chk("pfd_w1", ob_at(1), exp_w[5]);
      chk("pfd_prefix", pdc_prefix_num, 6'h2A);
      chk("pfd_strips", n_strip, 1);
      chk("pfd_cnt", pdc_strip_cnt, 1);
      chk("pfd_len", n_len, 0);
      chk("pfd_proto", n_proto, 0);
      chk("nopfd_count", ob2_q.size(), 6);
      bad = 0;
      foreach (exp_w[i]) if (ob2_q.size() <= i || ob2_q[i] !== exp_w[i]) bad++;
      chk("nopfd_words", bad, 0);
      chk("nopfd_cnt", strip_cnt2, 0);

      // short PHD: one data word instead of two
      clear_mon();
      ib_q.push_back(mk(1, 0, T_PHD, 64'h55));
      ib_q.push_back(mk(0, 1, T_PHD, 64'h400));
      run(15);
      chk("phd_count", ob_q.size(), 0);
      chk("phd_strip_len", n_strip_len, 1);
      chk("phd_len", n_len, 1);
      chk("phd_cnt", pdc_strip_cnt, 2);
      chk("phd_prefix", pdc_prefix_num, 6'h15);

      // framing: non-sot in idle, sot inside strip, single-word PFD
      clear_mon(); exp_w.delete();
      exp_w.push_back(mk(0, 1, T_DATA, 64'h500));
      exp_w.push_back(mk(1, 1, T_DATA, 64'h501));
      ib_q.push_back(exp_w[0]);
      ib_q.push_back(mk(1, 0, T_PFD, 64'h47));
      ib_q.push_back(mk(0, 0, T_PFD, 64'h600));
      ib_q.push_back(exp_w[1]);
      ib_q.push_back(mk(1, 1, T_PFD, 64'h63));
      run(25);
      chk("frm_count", ob_q.size(), 2);
      chk("frm_w0", ob_at(0), exp_w[0]);
      chk("frm_w1", ob_at(1), exp_w[1]);
      chk("frm_proto", n_proto, 2);
      chk("frm_proto_len", n_proto_len, 1);
      chk("frm_strips", n_strip, 2);
      chk("frm_len", n_len, 2);
      chk("frm_cnt", pdc_strip_cnt, 4);
      chk("frm_prefix", pdc_prefix_num, 6'h23);

      // backpressure: afull held, full toggling every 3 cycles
      clear_mon(); exp_w.delete();
      for (int i = 0; i < 16; i++)
         exp_w.push_back(mk(i == 0, i == 15, T_DATA, 64'h700 + 64'(i)));
      foreach (exp_w[i]) ib_q.push_back(exp_w[i]);
      usr_ob_afull = 1'b1; bp_k = 0; bp_en = 1;
      for (int i = 0; i < 400 && ob_q.size() < 16; i++) run(1);
      run(4);
      bp_en = 0; usr_ob_full = 1'b0; usr_ob_afull = 1'b0;
      chk("bp_count", ob_q.size(), 16);
      bad = 0;
      foreach (exp_w[i]) if (ob_q.size() <= i || ob_q[i] !== exp_w[i]) bad++;
      chk("bp_order", bad, 0);
      chk("bp_rd_full", rd_full_viol, 0);
      chk("bp_afull_pace", afull_viol, 0);
      run(4);

      // reset in the middle of a stripped TLV
      clear_mon();
      ib_q.push_back(mk(1, 0, T_PFD, 64'h7C));
      ib_q.push_back(mk(0, 0, T_PFD, 64'h800));
      ib_q.push_back(mk(0, 0, T_PFD, 64'h801));
      run(8);
      rst_n = 1'b0; ib_q.delete();
      run(2);
      chk("mid_rst_ob_wr",  usr_ob_wr, 0);
      chk("mid_rst_ob_tlv", usr_ob_tlv, 0);
      chk("mid_rst_cnt",    pdc_strip_cnt, 0);
      chk("mid_rst_prefix", pdc_prefix_num, 0);
      chk("mid_rst_ib_rd",  usr_ib_rd, 0);
      chk("mid_rst_strips", n_strip, 0);
      rst_n = 1'b1;
      run(2);
      clear_mon();
      ib_q.push_back(mk(1, 0, T_PFD, 64'h91));
      for (int i = 0; i < 3; i++) ib_q.push_back(mk(0, i == 2, T_PFD, 64'h900 + 64'(i)));
      run(20);
      chk("post_rst_cnt", pdc_strip_cnt, 1);
      chk("post_rst_prefix", pdc_prefix_num, 6'h11);
      chk("post_rst_strips", n_strip, 1);
      chk("post_rst_len", n_len, 0);
      chk("post_rst_count", ob_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cr_prefix_detach_ctlr.md
Name: cr_prefix_detach_ctlr

Overview:
Receive-side counterpart of the prefix attach controller. It reads a TLV stream from the user inbound FIFO and removes complete PFD and PHD TLVs (sot word through eot word). All other TLVs are forwarded unchanged to the outbound FIFO. For each removed TLV it checks the length and captures the prefix number, reporting errors and statistics to the register block.

Parameters:
STRIP_PFD, 1, when 1 PFD TLVs are removed; when 0 they are forwarded.
STRIP_PHD, 1, when 1 PHD TLVs are removed; when 0 they are forwarded.
PFD_WORDS, `N_PFD_WORDS, required number of data words following the PFD sot word.
PHD_WORDS, `N_PHD_WORDS, required number of data words following the PHD sot word.

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous, active-low reset
usr_ib_empty  input  1  inbound FIFO empty
usr_ib_aempty  input  1  inbound FIFO almost empty (unused, kept for interface symmetry)
usr_ib_tlv  input  tlvp_if_bus_t  inbound word; read data is valid the cycle after usr_ib_rd
usr_ib_rd  output  1  inbound FIFO pop
usr_ob_full  input  1  outbound FIFO full
usr_ob_afull  input  1  outbound FIFO almost full (at most 2 free entries)
usr_ob_wr  output  1  outbound push
usr_ob_tlv  output  tlvp_if_bus_t  outbound word
pdc_prefix_num  output  6  tdata[5:0] of the last stripped sot word
pdc_strip_pulse  output  1  one-cycle pulse on the eot of a stripped TLV
pdc_len_err  output  1  one-cycle pulse on a stripped TLV whose length is wrong
pdc_proto_err  output  1  one-cycle pulse on a sot/eot framing violation
pdc_strip_cnt  output  32  number of stripped TLVs; wraps at 2^32

Behaviour:
- Reset values: all outputs 0; FSM in S_SOT; internal word counter 0; valid0 stage cleared. Reset is honoured mid-TLV: any partial TLV is abandoned and no pulses are emitted.
- Pipeline:
  - Stage 0: usr_ib_rd=1 → tlv0 captured and valid0 set the next cycle.
  - Stage 1: usr_ob_wr/usr_ob_tlv are registered.
  - Latency is 2 clocks from usr_ib_rd to usr_ob_wr for forwarded words.
- Flow control: usr_ib_rd = ~usr_ib_empty & ~usr_ob_full & ~(usr_ob_afull & (valid0 | usr_ob_wr)). This keeps in-flight words at or below the afull headroom, so usr_ob_wr is never asserted while usr_ob_full is set.
- A word is "strip type" when (typen==PFD & STRIP_PFD) | (typen==PHD & STRIP_PHD).
- FSM, evaluated only when valid0=1:
  - S_SOT:
    - Word with sot=1 and strip type: usr_ob_wr=0; capture pdc_prefix_num=tdata[5:0] and typen; clear the counter.
      - If eot=1 on the same word: 0 data words, so pdc_len_err=1 (PFD_WORDS≥1). pdc_strip_pulse=1, pdc_strip_cnt++. Stay in S_SOT.
      - Otherwise go to S_STRIP.
    - Word with sot=1, not strip type: forward it. If eot=0 go to S_PASS.
    - Word with sot=0: pdc_proto_err=1; forward it; stay in S_SOT.
  - S_PASS:
    - Forward every word.
    - eot=1 → S_SOT.
    - sot=1 → pdc_proto_err=1 and re-evaluate as in S_SOT (new TLV start).
  - S_STRIP:
    - Drop every word; counter increments and saturates at 255.
    - On eot=1: pdc_strip_pulse=1, pdc_strip_cnt++, pdc_len_err = (counter+1 != required words for the captured type). Go to S_SOT.
    - sot=1 inside S_STRIP: pdc_proto_err=1; close the current TLV as a stripped TLV with len_err=1, then re-evaluate the word as in S_SOT.
- When valid0=0: usr_ob_wr=0 next cycle; FSM and counter hold.
- Pulses are registered and are coincident with the cycle in which usr_ob_wr would have been asserted.
- If error pulses collide, each is emitted independently. The sot-in-STRIP case emits both proto_err and len_err in the same cycle.
- Upper-layer ordering is preserved; no reordering or buffering beyond the 2-stage pipeline.

Test Plan:
- Forward only: DATA TLV of 4 words (sot…eot) with no backpressure → 4 usr_ob_wr, identical words, first push 2 clocks after the first usr_ib_rd; no pulses.
- Strip PFD: PFD sot with tdata[5:0]=6'h2A, then PFD_WORDS data words with eot on the last, then a 2-word DATA TLV → only the DATA words are pushed; pdc_prefix_num=6'h2A; pdc_strip_pulse once; pdc_strip_cnt=1; pdc_len_err=0.
- Length error: PHD sot, then PHD_WORDS-1 data words ending in eot → strip_pulse=1 and len_err=1 on the same cycle; no words output.
- STRIP_PFD=0 variant: same PFD TLV → all PFD_WORDS+1 words forwarded; strip_cnt stays 0.
- Backpressure: hold usr_ob_afull=1 with usr_ob_full toggling every 3 cycles over a 16-word DATA TLV → no push while full; all 16 words delivered in order.
- Framing and reset:
  - Non-sot word in S_SOT → proto_err pulse and the word is forwarded.
  - Assert rst_n low in the middle of a stripped TLV → all outputs 0, no strip pulse; the next clean PFD TLV strips with strip_cnt=1.
